// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS sequencer: opcodes, ALU/mux
// select codes, the controller state set and the control-output bundle.
package mips_pkg;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ORI    = 6'h0d;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2b;

    localparam logic [2:0] ALU_FUNCT = 3'b111;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_SUB   = 3'b001;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        WB_R     = 4'd4,
        EXEC_I   = 4'd5,
        WB_I     = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        MEM_WB   = 4'd9,
        MEM_WR   = 4'd10,
        BRANCH   = 4'd11
    } state_t;

    typedef struct packed {
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       pcWrite;
        logic [1:0] pcSrc;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic       illegalOp;
        logic       instrDone;
    } ctrl_t;

    // True for every opcode the sequencer knows how to execute.
    function automatic logic opLegal(input logic [5:0] op);
        return (op == R_TYPE) || (op == ADDI) || (op == ORI) || (op == BEQ) ||
               (op == BNE) || (op == LW) || (op == SW);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the sequencer and the datapath: IR opcode, ALU flag and
// memory handshake in, mux selects and write enables out.
interface multicycle_control_if;
    logic [5:0] OP;
    logic       Zero;
    logic       mem_ready;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       illegal_op;
    logic       instr_done;

    modport master (
        input  OP, Zero, mem_ready,
        output IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA,
               ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, illegal_op, instr_done
    );

    modport slave (
        output OP, Zero, mem_ready,
        input  IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA,
               ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, illegal_op, instr_done
    );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational map from the registered state (plus OP, Zero, mem_ready for
// the few Mealy terms) to the datapath control bundle.
module mc_output_decode
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memReady,
    output ctrl_t      ctrl
);

    // Everything defaults to 0 so IDLE and unused encodings drive nothing.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.aluSrcB = SRCB_FOUR;
                ctrl.aluOp   = ALU_ADD;
                ctrl.pcSrc   = PCSRC_ALU;
                ctrl.irWrite = memReady;
                ctrl.pcWrite = memReady;
            end
            DECODE: begin
                ctrl.aluSrcB = SRCB_IMMSH;
                ctrl.aluOp   = ALU_ADD;
                if (!opLegal(op)) begin
                    ctrl.illegalOp = 1'b1;
                    ctrl.instrDone = 1'b1;
                end
            end
            EXEC_R: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_RT;
                ctrl.aluOp   = ALU_FUNCT;
            end
            WB_R: begin
                ctrl.regDst    = 1'b1;
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            EXEC_I: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = (op == ORI) ? ALU_OR : ALU_ADD;
            end
            WB_I: begin
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            MEM_ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            MEM_WB: begin
                ctrl.memtoReg  = 1'b1;
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            MEM_WR: begin
                ctrl.memWrite  = 1'b1;
                ctrl.iorD      = 1'b1;
                ctrl.instrDone = memReady;
            end
            BRANCH: begin
                ctrl.aluSrcA   = 1'b1;
                ctrl.aluSrcB   = SRCB_RT;
                ctrl.aluOp     = ALU_SUB;
                ctrl.pcSrc     = PCSRC_ALUOUT;
                ctrl.instrDone = 1'b1;
                ctrl.pcWrite   = ((op == BEQ) && zero) || ((op == BNE) && !zero);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: state register and next-state logic; output
// decode is delegated to mc_output_decode.
module multicycle_control
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t state;
    state_t stateNext;
    logic   armed;
    ctrl_t  ctrl;

    // Reset drops straight to IDLE; armed holds IDLE one extra cycle after
    // release so the first FETCH lands on the second edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= stateNext;
            armed <= 1'b1;
        end
    end

    // Next state: memory states hold until mem_ready, DECODE dispatches on OP.
    always_comb begin
        stateNext = IDLE;
        case (state)
            IDLE:     stateNext = armed ? FETCH : IDLE;
            FETCH:    stateNext = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.OP)
                    R_TYPE:   stateNext = EXEC_R;
                    ADDI, ORI: stateNext = EXEC_I;
                    LW, SW:   stateNext = MEM_ADDR;
                    BEQ, BNE: stateNext = BRANCH;
                    default:  stateNext = FETCH;
                endcase
            end
            EXEC_R:   stateNext = WB_R;
            WB_R:     stateNext = FETCH;
            EXEC_I:   stateNext = WB_I;
            WB_I:     stateNext = FETCH;
            MEM_ADDR: stateNext = (bus.OP == LW) ? MEM_RD : MEM_WR;
            MEM_RD:   stateNext = bus.mem_ready ? MEM_WB : MEM_RD;
            MEM_WB:   stateNext = FETCH;
            MEM_WR:   stateNext = bus.mem_ready ? FETCH : MEM_WR;
            BRANCH:   stateNext = FETCH;
            default:  stateNext = IDLE;
        endcase
    end

    mc_output_decode uDecode (
        .state    (state),
        .op       (bus.OP),
        .zero     (bus.Zero),
        .memReady (bus.mem_ready),
        .ctrl     (ctrl)
    );

    assign bus.IorD       = ctrl.iorD;
    assign bus.MemRead    = ctrl.memRead;
    assign bus.MemWrite   = ctrl.memWrite;
    assign bus.IRWrite    = ctrl.irWrite;
    assign bus.PCWrite    = ctrl.pcWrite;
    assign bus.PCSrc      = ctrl.pcSrc;
    assign bus.ALUSrcA    = ctrl.aluSrcA;
    assign bus.ALUSrcB    = ctrl.aluSrcB;
    assign bus.ALUOp      = ctrl.aluOp;
    assign bus.RegDst     = ctrl.regDst;
    assign bus.MemtoReg   = ctrl.memtoReg;
    assign bus.RegWrite   = ctrl.regWrite;
    assign bus.illegal_op = ctrl.illegalOp;
    assign bus.instr_done = ctrl.instrDone;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded
// into its list of phases; every cycle the observed output word is set
// against the word the phase table prescribes.
module tb_multicycle_control;

    localparam int K_FETCH = 0;
    localparam int K_DEC   = 1;
    localparam int K_DILL  = 2;
    localparam int K_ER    = 3;
    localparam int K_WR    = 4;
    localparam int K_EI    = 5;
    localparam int K_WI    = 6;
    localparam int K_MA    = 7;
    localparam int K_MR    = 8;
    localparam int K_MW    = 9;
    localparam int K_MWR   = 10;
    localparam int K_BR    = 11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Output word: IorD MemRead MemWrite IRWrite PCWrite PCSrc[2] ALUSrcA
    // ALUSrcB[2] ALUOp[3] RegDst MemtoReg RegWrite illegal_op instr_done
    logic [17:0] obsVec;
    assign obsVec = {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite,
                     bus.PCSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegDst,
                     bus.MemtoReg, bus.RegWrite, bus.illegal_op, bus.instr_done};

    logic [17:0] obsA[128];
    logic [17:0] expA[128];
    int          nCyc;
    int          waitsUsed;
    int          planLen;

    function automatic logic [17:0] mk(input logic iord, input logic mr, input logic mw,
                                       input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic sa, input logic [1:0] sb, input logic [2:0] aop,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic ill, input logic done);
        return {iord, mr, mw, irw, pcw, pcs, sa, sb, aop, rd, m2r, rw, ill, done};
    endfunction

    function automatic logic [17:0] expVec(input int kind, input logic [5:0] op,
                                           input logic zero, input logic rdy);
        case (kind)
            K_FETCH: return mk(0, 1, 0, rdy, rdy, 2'b00, 0, 2'b01, 3'b100, 0, 0, 0, 0, 0);
            K_DEC:   return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b100, 0, 0, 0, 0, 0);
            K_DILL:  return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b100, 0, 0, 0, 1, 1);
            K_ER:    return mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b111, 0, 0, 0, 0, 0);
            K_WR:    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 1, 0, 1);
            K_EI:    return mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b10,
                               (op == 6'h0d) ? 3'b101 : 3'b100, 0, 0, 0, 0, 0);
            K_WI:    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 1, 0, 1);
            K_MA:    return mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b100, 0, 0, 0, 0, 0);
            K_MR:    return mk(1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
            K_MW:    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1, 1, 0, 1);
            K_MWR:   return mk(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, rdy);
            K_BR:    return mk(0, 0, 0, 0, (op == 6'h04) ? zero : !zero, 2'b01, 1, 2'b00,
                               3'b001, 0, 0, 0, 0, 1);
            default: return 18'h0;
        endcase
    endfunction

    function automatic bit isWait(input int kind);
        return (kind == K_FETCH) || (kind == K_MR) || (kind == K_MWR);
    endfunction

    task automatic buildPlan(input logic [5:0] op, output int steps[6], output int len);
        steps = '{default: 0};
        steps[0] = K_FETCH;
        steps[1] = K_DEC;
        len = 2;
        case (op)
            6'h00:        begin steps[2] = K_ER; steps[3] = K_WR; len = 4; end
            6'h08, 6'h0d: begin steps[2] = K_EI; steps[3] = K_WI; len = 4; end
            6'h23:        begin steps[2] = K_MA; steps[3] = K_MR; steps[4] = K_MW; len = 5; end
            6'h2b:        begin steps[2] = K_MA; steps[3] = K_MWR; len = 4; end
            6'h04, 6'h05: begin steps[2] = K_BR; len = 3; end
            default:      begin steps[1] = K_DILL; len = 2; end
        endcase
    endtask

    // Runs one instruction starting in FETCH; records observed/expected words.
    task automatic runInstr(input logic [5:0] op, input logic zero, input int fetchWait,
                            input int memWait, input bit randWait);
        int steps[6];
        int idx;
        int waited;
        logic rdy;
        buildPlan(op, steps, planLen);
        idx = 0;
        waited = 0;
        nCyc = 0;
        waitsUsed = 0;
        while (idx < planLen) begin
            @(negedge clk);
            if (isWait(steps[idx])) begin
                if (randWait) rdy = (waited >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
                else rdy = (waited >= ((steps[idx] == K_FETCH) ? fetchWait : memWait));
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            bus.OP = (steps[idx] == K_FETCH) ? 6'($urandom) : op;
            bus.Zero = zero;
            bus.mem_ready = rdy;
            #1;
            obsA[nCyc] = obsVec;
            expA[nCyc] = expVec(steps[idx], op, zero, rdy);
            nCyc++;
            if (isWait(steps[idx]) && !rdy) begin
                waited++;
                waitsUsed++;
            end else begin
                idx++;
                waited = 0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.OP = 6'h23;
        bus.Zero = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (obsVec !== 18'h0) begin
                errors++;
                $display("FAIL reset_held got %h exp %h", obsVec, 18'h0);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obsVec !== 18'h0) begin
            errors++;
            $display("FAIL reset_rel1 got %h exp %h", obsVec, 18'h0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obsVec !== 18'h0) begin
            errors++;
            $display("FAIL reset_rel2 got %h exp %h", obsVec, 18'h0);
        end
    endtask

    task automatic test_addi;
        runInstr(6'h08, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < nCyc; i++) begin
            checks++;
            if (obsA[i] !== expA[i]) begin
                errors++;
                $display("FAIL addi_cyc%0d got %h exp %h", i, obsA[i], expA[i]);
            end
        end
        checks++;
        if (nCyc !== 4 || obsA[3][0] !== 1'b1) begin
            errors++;
            $display("FAIL addi_latency got %0d done %b exp 4 done 1", nCyc, obsA[3][0]);
        end
        checks++;
        if (obsA[2][9:5] !== 5'b10100) begin
            errors++;
            $display("FAIL addi_exec got %b exp %b", obsA[2][9:5], 5'b10100);
        end
    endtask

    task automatic test_lw_wait;
        runInstr(6'h23, 1'b0, 0, 2, 1'b0);
        for (int i = 0; i < nCyc; i++) begin
            checks++;
            if (obsA[i] !== expA[i]) begin
                errors++;
                $display("FAIL lw_cyc%0d got %h exp %h", i, obsA[i], expA[i]);
            end
        end
        checks++;
        if (nCyc !== 7) begin
            errors++;
            $display("FAIL lw_latency got %0d exp 7", nCyc);
        end
        for (int i = 3; i < 6; i++) begin
            checks++;
            if (obsA[i][17:16] !== 2'b11) begin
                errors++;
                $display("FAIL lw_memrd%0d got %b exp 11", i, obsA[i][17:16]);
            end
        end
        checks++;
        if (obsA[6][3:2] !== 2'b11 || obsA[6][0] !== 1'b1) begin
            errors++;
            $display("FAIL lw_wb got %b exp 11/1", obsA[6][3:0]);
        end
    endtask

    task automatic test_branch;
        logic [5:0] ops[2];
        ops[0] = 6'h04;
        ops[1] = 6'h05;
        for (int b = 0; b < 2; b++) begin
            for (int z = 0; z < 2; z++) begin
                runInstr(ops[b], 1'(z), 0, 0, 1'b0);
                for (int i = 0; i < nCyc; i++) begin
                    checks++;
                    if (obsA[i] !== expA[i]) begin
                        errors++;
                        $display("FAIL br%0d_z%0d_cyc%0d got %h exp %h", b, z, i, obsA[i], expA[i]);
                    end
                end
                checks++;
                // Taken exactly when BEQ sees Zero or BNE sees !Zero.
                if (nCyc !== 3 || obsA[2][13] !== 1'(b == z ? 0 : 1) ^ 1'(b == 0 ? 0 : 0)
                    || obsA[2][12:11] !== 2'b01) begin
                    errors++;
                    $display("FAIL br%0d_z%0d_pc got n=%0d pcw=%b pcs=%b", b, z, nCyc,
                             obsA[2][13], obsA[2][12:11]);
                end
            end
        end
    endtask

    task automatic test_illegal;
        runInstr(6'h3f, 1'b0, 0, 0, 1'b0);
        checks++;
        if (nCyc !== 2 || obsA[1][1:0] !== 2'b11) begin
            errors++;
            $display("FAIL illegal got n=%0d ill/done=%b exp 2/11", nCyc, obsA[1][1:0]);
        end
        for (int i = 0; i < nCyc; i++) begin
            checks++;
            if (obsA[i] !== expA[i] || obsA[i][2] !== 1'b0 || obsA[i][15] !== 1'b0) begin
                errors++;
                $display("FAIL illegal_cyc%0d got %h exp %h", i, obsA[i], expA[i]);
            end
        end
    endtask

    task automatic test_sw_fetch_wait;
        runInstr(6'h2b, 1'b1, 3, 0, 1'b0);
        for (int i = 0; i < nCyc; i++) begin
            checks++;
            if (obsA[i] !== expA[i]) begin
                errors++;
                $display("FAIL sw_cyc%0d got %h exp %h", i, obsA[i], expA[i]);
            end
        end
        checks++;
        if (nCyc !== 7 || obsA[0][14:13] !== 2'b00 || obsA[2][14:13] !== 2'b00
            || obsA[3][14:13] !== 2'b11) begin
            errors++;
            $display("FAIL sw_fetch got n=%0d irw/pcw %b %b exp 7 00 11", nCyc,
                     obsA[2][14:13], obsA[3][14:13]);
        end
        checks++;
        if (obsA[6][15] !== 1'b1 || obsA[6][0] !== 1'b1) begin
            errors++;
            $display("FAIL sw_memwr got mw=%b done=%b exp 1 1", obsA[6][15], obsA[6][0]);
        end
    endtask

    task automatic test_reset_mid_lw;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.OP = 6'h23;
            bus.mem_ready = 1'b1;
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (obsVec[17:16] !== 2'b11) begin
            errors++;
            $display("FAIL rstlw_memrd got %b exp 11", obsVec[17:16]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obsVec !== 18'h0) begin
            errors++;
            $display("FAIL rstlw_async got %h exp %h", obsVec, 18'h0);
        end
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obsVec !== 18'h0) begin
            errors++;
            $display("FAIL rstlw_held got %h exp %h", obsVec, 18'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obsVec !== 18'h0) begin
            errors++;
            $display("FAIL rstlw_idle1 got %h exp %h", obsVec, 18'h0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obsVec !== 18'h0) begin
            errors++;
            $display("FAIL rstlw_idle2 got %h exp %h", obsVec, 18'h0);
        end
        runInstr(6'h00, 1'b0, 0, 0, 1'b0);
        checks++;
        if (obsA[0][17:16] !== 2'b01) begin
            errors++;
            $display("FAIL rstlw_fetch got %b exp 01", obsA[0][17:16]);
        end
        for (int i = 0; i < nCyc; i++) begin
            checks++;
            if (obsA[i] !== expA[i]) begin
                errors++;
                $display("FAIL rstlw_r_cyc%0d got %h exp %h", i, obsA[i], expA[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] opTab[8];
        logic [5:0] op;
        int         dones;
        opTab = '{6'h00, 6'h08, 6'h0d, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h3f};
        for (int n = 0; n < 40; n++) begin
            op = (($urandom_range(0, 7)) == 0) ? 6'($urandom) : opTab[$urandom_range(0, 7)];
            runInstr(op, 1'($urandom_range(0, 1)), 0, 0, 1'b1);
            dones = 0;
            for (int i = 0; i < nCyc; i++) begin
                dones += int'(obsA[i][0]);
                checks++;
                if (obsA[i] !== expA[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_op%h_cyc%0d got %h exp %h", n, op, i, obsA[i], expA[i]);
                end
            end
            checks++;
            if (dones !== 1 || obsA[nCyc-1][0] !== 1'b1) begin
                errors++;
                $display("FAIL rnd%0d_done got %0d pulses exp 1 on last cycle", n, dones);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.OP = 6'h0;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset;
        test_addi;
        test_lw_wait;
        test_branch;
        test_illegal;
        test_sw_fetch_wait;
        test_reset_mid_lw;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the MIPS core. It replaces single-cycle opcode decode with a state machine that drives the shared ALU, unified memory port, instruction register and PC over several cycles per instruction. It sits between the instruction register (OP), ALU (Zero) and memory (mem_ready), and the datapath muxes and enables.

## Interface
Parameters:
- none. Opcodes, ALUOp codes and state encoding come from the shared package.

Ports:
- clk  in  1  core clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- OP  in  6  opcode from the IR; stable outside FETCH.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  load IR (and MDR) from memory.
- PCWrite  out  1  load PC.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut (branch target).
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- ALUOp  out  3  111 = R-type/funct, 100 = add, 101 = or, 001 = sub.
- RegDst  out  1  1 = rd, 0 = rt.
- MemtoReg  out  1  1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register-file write enable.
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- instr_done  out  1  one-cycle pulse on the last cycle of every instruction.

## Operation
- Supported opcodes: R-type 0x00, ADDI 0x08, ORI 0x0d, BEQ 0x04, BNE 0x05, LW 0x23, SW 0x2b.
- States and outputs. Unlisted outputs are 0. Next state follows the arrow.
  - IDLE: all 0 -> FETCH.
  - FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSrc=00. IRWrite=PCWrite=mem_ready. Stays in FETCH while !mem_ready; -> DECODE when mem_ready.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=100. Next state by OP:
    - R-type -> EXEC_R.
    - ADDI/ORI -> EXEC_I.
    - LW/SW -> MEM_ADDR.
    - BEQ/BNE -> BRANCH.
    - otherwise: illegal_op=1, instr_done=1 -> FETCH (executes as a NOP; PC already advanced).
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111 -> WB_R.
  - WB_R: RegDst=1, RegWrite, instr_done -> FETCH.
  - EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=100 (ADDI) or 101 (ORI) -> WB_I.
  - WB_I: RegDst=0, RegWrite, instr_done -> FETCH.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=100 -> MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD: MemRead, IorD=1. Holds until mem_ready -> MEM_WB.
  - MEM_WB: MemtoReg, RegWrite, RegDst=0, instr_done -> FETCH.
  - MEM_WR: MemWrite, IorD=1, instr_done=mem_ready. Holds until mem_ready -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSrc=01, instr_done. PCWrite=(BEQ&Zero)|(BNE&!Zero) -> FETCH.
- Memory handshake:
  - MemRead/MemWrite and IorD stay constant until mem_ready.
  - mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- Output types:
  - Moore decode of state for all outputs, except the mem_ready-gated enables, BRANCH PCWrite and DECODE illegal_op (Mealy).
  - All outputs are glitch-free relative to the registered state.

## Timing
- Reset:
  - Asserting reset forces IDLE immediately, mid-instruction included.
  - All outputs are 0 while reset is asserted and in the first cycle after release.
  - FETCH is entered on the second rising edge after release.
  - No RegWrite, MemWrite or PCWrite occurs from an aborted instruction.
- Latency with zero-wait memory (mem_ready constantly 1):
  - R/ADDI/ORI/SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ/BNE: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- instr_done pulses exactly once per instruction. The following cycle is FETCH.
- State register: 4 bits, 12 states. An unreachable encoding recovers to IDLE on the next edge.

## Structure
- mips_pkg holds:
  - opcode localparams (R_TYPE, ADDI, ORI, BEQ, BNE, LW, SW);
  - ALUOp codes;
  - ALUSrcB/PCSrc codes;
  - the state_t enum.
- One sub-module, mc_output_decode, maps state_t, OP, Zero and mem_ready to the output bus (combinational).
- Next-state logic and the async-reset state register live in multicycle_control.

## Test plan
- Reset mid-LW:
  - Stimulus: assert reset in MEM_RD.
  - Required: all outputs 0 that cycle, no RegWrite; after release, IDLE then FETCH with MemRead=1, IorD=0.
- ADDI (OP=0x08) with mem_ready=1:
  - Required: states FETCH, DECODE, EXEC_I (ALUOp=100, ALUSrcB=10), WB_I (RegWrite=1, RegDst=0); instr_done on cycle 4.
- LW (OP=0x23) with 2 wait cycles in MEM_RD:
  - Required: MemRead=1, IorD=1 held for 3 cycles; MEM_WB has MemtoReg=1, RegWrite=1; 7 cycles total.
- BEQ (OP=0x04):
  - Zero=1: PCWrite=1 and PCSrc=01 in BRANCH.
  - Zero=0: PCWrite=0.
  - BNE (0x05) gives the inverse results.
- Illegal opcode (OP=0x3f):
  - Required: illegal_op=1 and instr_done=1 in DECODE; next state FETCH; no RegWrite or MemWrite.
- SW (OP=0x2b) with mem_ready held 0 in FETCH for 3 cycles:
  - Required: IRWrite=PCWrite=0 until mem_ready; MEM_WR asserts MemWrite=1; instr_done coincides with mem_ready.
